// File: rtl/ddr_arb_pkg.sv
// Shared types and constants for the DDR read arbiter.
//   ddr_arb_state_e : arbiter FSM states
//   AXI_BURST_INCR  : AXI4 INCR burst encoding
//   AXI_RESP_OKAY   : AXI4 OKAY response encoding
//   axi_size()      : log2 of bytes per beat for a given data width
package ddr_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } ddr_arb_state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // Evaluated at elaboration for a constant width; widths are powers of two >= 8.
    function automatic logic [2:0] axi_size(input int unsigned data_w);
        int unsigned bytes;
        logic [2:0]  size;
        bytes = data_w / 8;
        size  = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if ((32'd1 << i) == bytes) begin
                size = 3'(i);
            end
        end
        return size;
    endfunction

endpackage

// File: rtl/ddr_rd_arbiter_if.sv
// Bundle of all handshake/bus signals around the DDR read arbiter.
//   req0/req1 : burst request (valid/ready/addr/len) from each line fetcher
//   rd0/rd1   : returned beats (data/valid/last/ready) to each line fetcher
//   m_axi_*   : AXI4 AR and R channels towards DDR
//   err/err_src : sticky error flag and the requester that owned the failing burst
// Modport master is the arbiter's view; slave is the surrounding environment.
interface ddr_rd_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 8
);
    logic              req0_valid;
    logic              req0_ready;
    logic [ADDR_W-1:0] req0_addr;
    logic [LEN_W-1:0]  req0_len;
    logic              req1_valid;
    logic              req1_ready;
    logic [ADDR_W-1:0] req1_addr;
    logic [LEN_W-1:0]  req1_len;

    logic [DATA_W-1:0] rd0_data;
    logic              rd0_valid;
    logic              rd0_last;
    logic              rd0_ready;
    logic [DATA_W-1:0] rd1_data;
    logic              rd1_valid;
    logic              rd1_last;
    logic              rd1_ready;

    logic [ADDR_W-1:0] m_axi_araddr;
    logic [LEN_W-1:0]  m_axi_arlen;
    logic [2:0]        m_axi_arsize;
    logic [1:0]        m_axi_arburst;
    logic              m_axi_arvalid;
    logic              m_axi_arready;
    logic [DATA_W-1:0] m_axi_rdata;
    logic [1:0]        m_axi_rresp;
    logic              m_axi_rlast;
    logic              m_axi_rvalid;
    logic              m_axi_rready;

    logic              err;
    logic              err_src;

    modport master (
        input  req0_valid, req0_addr, req0_len, req1_valid, req1_addr, req1_len,
        output req0_ready, req1_ready,
        output rd0_data, rd0_valid, rd0_last, rd1_data, rd1_valid, rd1_last,
        input  rd0_ready, rd1_ready,
        output m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
        input  m_axi_arready,
        input  m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        output m_axi_rready,
        output err, err_src
    );

    modport slave (
        output req0_valid, req0_addr, req0_len, req1_valid, req1_addr, req1_len,
        input  req0_ready, req1_ready,
        input  rd0_data, rd0_valid, rd0_last, rd1_data, rd1_valid, rd1_last,
        output rd0_ready, rd1_ready,
        input  m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
        output m_axi_arready,
        output m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        input  m_axi_rready,
        input  err, err_src
    );

endinterface

// File: rtl/ddr_rd_arbiter.sv
// Two-requester round-robin read arbiter sharing one AXI4 read channel.
//   aclk    : clock
//   aresetn : asynchronous active-low reset
//   bus     : ddr_rd_arbiter_if.master -- requests, returned beats, AXI AR/R, err/err_src
// One AR transaction in flight at a time; R beats are steered combinationally to the
// granted requester with no buffering.
module ddr_rd_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 8
) (
    input  logic             aclk,
    input  logic             aresetn,
    ddr_rd_arbiter_if.master bus
);

    ddr_arb_state_e    state_q, state_d;
    logic              grant_q, grant_d;
    logic              last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              err_src_q, err_src_d;

    logic any_req;
    logic pick;
    logic cnt_zero;
    logic rready;
    logic beat_hs;
    logic beat_bad;

    assign any_req  = bus.req0_valid | bus.req1_valid;
    // Both pending: take the one that lost last time; otherwise take whichever is pending.
    assign pick     = (bus.req0_valid & bus.req1_valid) ? ~last_grant_q : bus.req1_valid;
    assign cnt_zero = (cnt_q == '0);

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        err_src_d    = err_src_q;
        rready       = 1'b0;
        beat_hs      = 1'b0;
        beat_bad     = 1'b0;

        bus.req0_ready    = 1'b0;
        bus.req1_ready    = 1'b0;
        bus.rd0_data      = '0;
        bus.rd0_valid     = 1'b0;
        bus.rd0_last      = 1'b0;
        bus.rd1_data      = '0;
        bus.rd1_valid     = 1'b0;
        bus.rd1_last      = 1'b0;
        bus.m_axi_araddr  = addr_q;
        bus.m_axi_arlen   = len_q;
        bus.m_axi_arsize  = axi_size(DATA_W);
        bus.m_axi_arburst = AXI_BURST_INCR;
        bus.m_axi_arvalid = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d        = pick;
                    addr_d         = pick ? bus.req1_addr : bus.req0_addr;
                    len_d          = pick ? bus.req1_len : bus.req0_len;
                    bus.req0_ready = ~pick;
                    bus.req1_ready = pick;
                    state_d        = ADDR;
                end
            end
            ADDR: begin
                bus.m_axi_arvalid = 1'b1;
                if (bus.m_axi_arready) begin
                    cnt_d   = len_q;
                    state_d = DATA;
                end
            end
            DATA: begin
                rready = grant_q ? bus.rd1_ready : bus.rd0_ready;
                if (grant_q) begin
                    bus.rd1_valid = bus.m_axi_rvalid;
                    bus.rd1_data  = bus.m_axi_rdata;
                    bus.rd1_last  = cnt_zero;
                end else begin
                    bus.rd0_valid = bus.m_axi_rvalid;
                    bus.rd0_data  = bus.m_axi_rdata;
                    bus.rd0_last  = cnt_zero;
                end
                beat_hs = bus.m_axi_rvalid & rready;
                if (beat_hs) begin
                    // rlast is only checked; the local counter alone ends the burst.
                    beat_bad = (bus.m_axi_rresp != AXI_RESP_OKAY) |
                               (bus.m_axi_rlast != cnt_zero);
                    cnt_d    = cnt_q - 1'b1;
                    if (cnt_zero) begin
                        last_grant_d = grant_q;
                        state_d      = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (beat_bad && !err_q) begin
            err_d     = 1'b1;
            err_src_d = grant_q;
        end
    end

    assign bus.m_axi_rready = rready;
    assign bus.err          = err_q;
    assign bus.err_src      = err_src_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            addr_q       <= '0;
            len_q        <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            err_src_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            err_src_q    <= err_src_d;
        end
    end

endmodule
